// File: rtl/dispense_sequencer_if.sv
// Control/status bundle between the selection FSM (master) and the dispense sequencer (slave).
// Command inputs are level-sampled; status outputs are registered or decoded from registered state.
interface dispense_sequencer_if;
   logic       start;
   logic       size;
   logic       hold;
   logic       abort;
   logic [3:0] act;
   logic [1:0] step;
   logic       busy;
   logic       step_done;
   logic       done;
   logic       aborted;

   modport master (
      output start, size, hold, abort,
      input  act, step, busy, step_done, done, aborted
   );

   modport slave (
      input  start, size, hold, abort,
      output act, step, busy, step_done, done, aborted
   );
endinterface

// File: rtl/dispense_sequencer.sv
// Four-step actuator timing sequencer; starts one cycle after start is sampled in IDLE.
// Pulses and actuator enables come from registered state; hold pauses without losing active cycles.
module dispense_sequencer #(
   parameter int CNT_W = 8,
   parameter int S_T0  = 4,
   parameter int S_T1  = 6,
   parameter int S_T2  = 3,
   parameter int S_T3  = 2,
   parameter int L_T0  = 8,
   parameter int L_T1  = 12,
   parameter int L_T2  = 6,
   parameter int L_T3  = 2
) (
   input  logic                 clk,
   input  logic                 rst,
   dispense_sequencer_if.slave  bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      PAUSE = 2'd2,
      DONE  = 2'd3
   } state_t;

   state_t             state_q, state_d;
   logic [1:0]         step_q, step_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               size_q, size_d;
   logic               step_done_q, step_done_d;
   logic               aborted_q, aborted_d;

   // Counter load value is duration minus one so the last active cycle sees cnt == 0.
   function automatic logic [CNT_W-1:0] dur_m1(input logic sz, input logic [1:0] k);
      int t;
      t = 1;
      case (k)
         2'd0:    t = sz ? L_T0 : S_T0;
         2'd1:    t = sz ? L_T1 : S_T1;
         2'd2:    t = sz ? L_T2 : S_T2;
         default: t = sz ? L_T3 : S_T3;
      endcase
      return CNT_W'(t - 1);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         step_q      <= 2'd0;
         cnt_q       <= '0;
         size_q      <= 1'b0;
         step_done_q <= 1'b0;
         aborted_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         step_q      <= step_d;
         cnt_q       <= cnt_d;
         size_q      <= size_d;
         step_done_q <= step_done_d;
         aborted_q   <= aborted_d;
      end
   end

   always_comb begin
      state_d     = state_q;
      step_d      = step_q;
      cnt_d       = cnt_q;
      size_d      = size_q;
      step_done_d = 1'b0;
      aborted_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (bus.start && !bus.abort) begin
               size_d  = bus.size;
               step_d  = 2'd0;
               cnt_d   = dur_m1(bus.size, 2'd0);
               state_d = RUN;
            end
         end
         RUN: begin
            if (bus.abort) begin
               state_d   = IDLE;
               step_d    = 2'd0;
               aborted_d = 1'b1;
            end else begin
               if (cnt_q != '0) begin
                  cnt_d = cnt_q - CNT_W'(1);
               end else begin
                  step_done_d = 1'b1;
                  if (step_q != 2'd3) begin
                     step_d = step_q + 2'd1;
                     cnt_d  = dur_m1(size_q, step_q + 2'd1);
                  end else begin
                     state_d = DONE;
                  end
               end
               // The finishing cycle of the last step goes to DONE even when hold is raised.
               if (bus.hold && !(cnt_q == '0 && step_q == 2'd3)) begin
                  state_d = PAUSE;
               end
            end
         end
         PAUSE: begin
            if (bus.abort) begin
               state_d   = IDLE;
               step_d    = 2'd0;
               aborted_d = 1'b1;
            end else if (!bus.hold) begin
               state_d = RUN;
            end
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign bus.act       = (state_q == RUN) ? (4'b0001 << step_q) : 4'b0000;
   assign bus.step      = step_q;
   assign bus.busy      = (state_q != IDLE);
   assign bus.step_done = step_done_q;
   assign bus.done      = (state_q == DONE);
   assign bus.aborted   = aborted_q;

endmodule

// File: tb/tb_dispense_sequencer.sv
// Directed bench for dispense_sequencer: timed runs, pause, abort, corner cases and mid-run reset.
module tb_dispense_sequencer;

   localparam int MAXC = 80;
   localparam int NONE = 999;

   logic clk;
   logic rst;
   int   n_checks;
   int   n_fail;

   dispense_sequencer_if dif ();

   dispense_sequencer dut (
      .clk (clk),
      .rst (rst),
      .bus (dif.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Per-run observations, indexed by cycle number after the edge that samples start.
   logic [3:0] tr_act  [0:MAXC];
   logic [1:0] tr_step [0:MAXC];
   logic       tr_sd   [0:MAXC];
   int         act_cnt [4];
   int         sd_cnt, ab_cnt, done_cyc, abort_cyc, end_cyc, bad_act, post_pulses;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_seq(input logic sz, input int hold_at, input int hold_len,
                          input int abort_at, input int restart_at);
      int cyc;
      for (int k = 0; k < 4; k++) act_cnt[k] = 0;
      sd_cnt = 0; ab_cnt = 0; done_cyc = -1; abort_cyc = -1; end_cyc = -1;
      bad_act = 0; post_pulses = 0;
      dif.start = 1'b1;
      dif.size  = sz;
      cyc = 0;
      while (end_cyc < 0 && cyc < MAXC) begin
         tick();
         cyc++;
         tr_act[cyc]  = dif.act;
         tr_step[cyc] = dif.step;
         tr_sd[cyc]   = dif.step_done;
         case (dif.act)
            4'b0000: ;
            4'b0001: act_cnt[0]++;
            4'b0010: act_cnt[1]++;
            4'b0100: act_cnt[2]++;
            4'b1000: act_cnt[3]++;
            default: bad_act++;
         endcase
         if (dif.step_done) sd_cnt++;
         if (dif.aborted) begin ab_cnt++; abort_cyc = cyc; end
         if (dif.done) done_cyc = cyc;
         if (!dif.busy) end_cyc = cyc;
         dif.start = (cyc == restart_at);
         dif.hold  = (cyc >= hold_at && cyc < hold_at + hold_len);
         dif.abort = (cyc == abort_at);
      end
      dif.start = 1'b0; dif.hold = 1'b0; dif.abort = 1'b0; dif.size = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick();
         if (dif.done || dif.aborted || dif.step_done || dif.busy) post_pulses++;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      dif.start = 1'b0; dif.size = 1'b0; dif.hold = 1'b0; dif.abort = 1'b0;
      tick(); tick(); tick();
      n_checks++;
      if ({dif.act, dif.step, dif.busy, dif.step_done, dif.done, dif.aborted} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got act=%b step=%0d busy=%b sd=%b done=%b ab=%b, want all 0",
                  dif.act, dif.step, dif.busy, dif.step_done, dif.done, dif.aborted);
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (dif.busy !== 1'b0) begin
         n_fail++; $display("FAIL reset_idle_busy: got %b want 0", dif.busy);
      end
   endtask

   task automatic test_small();
      int exp_dur [4] = '{4, 6, 3, 2};
      int sd_at [4] = '{5, 11, 14, 16};
      run_seq(1'b0, NONE, 0, NONE, NONE);
      n_checks++;
      if (done_cyc !== 16) begin n_fail++; $display("FAIL small_done_cycle: got %0d want 16", done_cyc); end
      n_checks++;
      if (end_cyc !== 17) begin n_fail++; $display("FAIL small_busy_drop: got %0d want 17", end_cyc); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (act_cnt[k] !== exp_dur[k]) begin
            n_fail++; $display("FAIL small_act_len step%0d: got %0d want %0d", k, act_cnt[k], exp_dur[k]);
         end
         n_checks++;
         if (tr_sd[sd_at[k]] !== 1'b1) begin
            n_fail++; $display("FAIL small_step_done_at cyc%0d: got %b want 1", sd_at[k], tr_sd[sd_at[k]]);
         end
      end
      n_checks++;
      if (sd_cnt !== 4) begin n_fail++; $display("FAIL small_step_done_count: got %0d want 4", sd_cnt); end
      n_checks++;
      if (tr_act[1] !== 4'b0001 || tr_act[5] !== 4'b0010 || tr_act[12] !== 4'b0100 || tr_act[15] !== 4'b1000) begin
         n_fail++; $display("FAIL small_act_order: got %b %b %b %b want 0001 0010 0100 1000",
                            tr_act[1], tr_act[5], tr_act[12], tr_act[15]);
      end
      n_checks++;
      if (bad_act !== 0) begin n_fail++; $display("FAIL small_onehot: got %0d bad act values want 0", bad_act); end
      n_checks++;
      if (tr_step[17] !== 2'd3) begin n_fail++; $display("FAIL small_idle_step: got %0d want 3", tr_step[17]); end
      n_checks++;
      if (post_pulses !== 0) begin n_fail++; $display("FAIL small_post_quiet: got %0d want 0", post_pulses); end
   endtask

   task automatic test_large();
      int exp_dur [4] = '{8, 12, 6, 2};
      run_seq(1'b1, NONE, 0, NONE, NONE);
      n_checks++;
      if (done_cyc !== 29) begin n_fail++; $display("FAIL large_done_cycle: got %0d want 29", done_cyc); end
      n_checks++;
      if (end_cyc !== 30) begin n_fail++; $display("FAIL large_busy_drop: got %0d want 30", end_cyc); end
      for (int k = 0; k < 4; k++) begin
         n_checks++;
         if (act_cnt[k] !== exp_dur[k]) begin
            n_fail++; $display("FAIL large_act_len step%0d: got %0d want %0d", k, act_cnt[k], exp_dur[k]);
         end
      end
      n_checks++;
      if (sd_cnt !== 4) begin n_fail++; $display("FAIL large_step_done_count: got %0d want 4", sd_cnt); end
   endtask

   task automatic test_pause();
      int viol;
      run_seq(1'b0, 7, 5, NONE, NONE);
      viol = 0;
      for (int c = 8; c <= 12; c++) if (tr_act[c] !== 4'b0000 || tr_step[c] !== 2'd1) viol++;
      n_checks++;
      if (viol !== 0) begin n_fail++; $display("FAIL pause_frozen: got %0d bad cycles want 0", viol); end
      n_checks++;
      if (tr_act[7] !== 4'b0010 || tr_act[13] !== 4'b0010) begin
         n_fail++; $display("FAIL pause_edges: got %b %b want 0010 0010", tr_act[7], tr_act[13]);
      end
      n_checks++;
      if (act_cnt[1] !== 6) begin n_fail++; $display("FAIL pause_step1_len: got %0d want 6", act_cnt[1]); end
      n_checks++;
      if (done_cyc !== 21) begin n_fail++; $display("FAIL pause_done_cycle: got %0d want 21", done_cyc); end
      n_checks++;
      if (sd_cnt !== 4) begin n_fail++; $display("FAIL pause_step_done_count: got %0d want 4", sd_cnt); end
   endtask

   task automatic test_abort_run();
      run_seq(1'b1, NONE, 0, 23, NONE);
      n_checks++;
      if (tr_act[23] !== 4'b0100) begin n_fail++; $display("FAIL abort_run_step2: got %b want 0100", tr_act[23]); end
      n_checks++;
      if (abort_cyc !== 24 || end_cyc !== 24 || tr_act[24] !== 4'b0000) begin
         n_fail++; $display("FAIL abort_run_timing: got ab=%0d idle=%0d act=%b want 24 24 0000",
                            abort_cyc, end_cyc, tr_act[24]);
      end
      n_checks++;
      if (ab_cnt !== 1 || done_cyc !== -1 || post_pulses !== 0) begin
         n_fail++; $display("FAIL abort_run_pulses: got ab=%0d done=%0d post=%0d want 1 -1 0",
                            ab_cnt, done_cyc, post_pulses);
      end
      n_checks++;
      if (tr_step[24] !== 2'd0 || tr_sd[24] !== 1'b0) begin
         n_fail++; $display("FAIL abort_run_step: got step=%0d sd=%b want 0 0", tr_step[24], tr_sd[24]);
      end
   endtask

   task automatic test_abort_pause();
      run_seq(1'b0, 7, 10, 10, NONE);
      n_checks++;
      if (tr_act[10] !== 4'b0000 || tr_step[10] !== 2'd1) begin
         n_fail++; $display("FAIL abort_pause_paused: got act=%b step=%0d want 0000 1", tr_act[10], tr_step[10]);
      end
      n_checks++;
      if (abort_cyc !== 11 || end_cyc !== 11 || ab_cnt !== 1 || done_cyc !== -1) begin
         n_fail++; $display("FAIL abort_pause: got ab=%0d idle=%0d abcnt=%0d done=%0d want 11 11 1 -1",
                            abort_cyc, end_cyc, ab_cnt, done_cyc);
      end
      n_checks++;
      if (tr_step[11] !== 2'd0 || post_pulses !== 0) begin
         n_fail++; $display("FAIL abort_pause_after: got step=%0d post=%0d want 0 0", tr_step[11], post_pulses);
      end
   endtask

   task automatic test_start_abort();
      dif.start = 1'b1; dif.abort = 1'b1;
      tick();
      dif.start = 1'b0; dif.abort = 1'b0;
      n_checks++;
      if (dif.busy !== 1'b0 || dif.act !== 4'b0000) begin
         n_fail++; $display("FAIL start_abort_idle: got busy=%b act=%b want 0 0000", dif.busy, dif.act);
      end
      tick();
      n_checks++;
      if (dif.busy !== 1'b0) begin n_fail++; $display("FAIL start_abort_stays: got busy=%b want 0", dif.busy); end
   endtask

   task automatic test_start_busy();
      run_seq(1'b0, NONE, 0, NONE, 3);
      n_checks++;
      if (done_cyc !== 16 || act_cnt[0] !== 4 || act_cnt[1] !== 6) begin
         n_fail++; $display("FAIL start_busy_ignored: got done=%0d a0=%0d a1=%0d want 16 4 6",
                            done_cyc, act_cnt[0], act_cnt[1]);
      end
      n_checks++;
      if (post_pulses !== 0) begin n_fail++; $display("FAIL start_busy_no_rerun: got %0d want 0", post_pulses); end
   endtask

   task automatic test_hold_last();
      run_seq(1'b0, 15, 3, NONE, NONE);
      n_checks++;
      if (done_cyc !== 16 || end_cyc !== 17 || act_cnt[3] !== 2) begin
         n_fail++; $display("FAIL hold_last_done: got done=%0d idle=%0d a3=%0d want 16 17 2",
                            done_cyc, end_cyc, act_cnt[3]);
      end
   endtask

   task automatic test_reset_mid();
      dif.start = 1'b1; dif.size = 1'b0;
      for (int i = 1; i <= 6; i++) begin
         tick();
         if (i == 1) dif.start = 1'b0;
      end
      n_checks++;
      if (dif.act !== 4'b0010) begin n_fail++; $display("FAIL reset_mid_pre: got act=%b want 0010", dif.act); end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++;
      if ({dif.act, dif.step, dif.busy, dif.step_done, dif.done, dif.aborted} !== 10'd0) begin
         n_fail++; $display("FAIL reset_mid_outputs: got act=%b step=%0d busy=%b sd=%b done=%b ab=%b want all 0",
                            dif.act, dif.step, dif.busy, dif.step_done, dif.done, dif.aborted);
      end
      tick();
      run_seq(1'b0, NONE, 0, NONE, NONE);
      n_checks++;
      if (done_cyc !== 16 || sd_cnt !== 4 || act_cnt[2] !== 3) begin
         n_fail++; $display("FAIL reset_mid_rerun: got done=%0d sd=%0d a2=%0d want 16 4 3",
                            done_cyc, sd_cnt, act_cnt[2]);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst = 1'b1;
      dif.start = 1'b0; dif.size = 1'b0; dif.hold = 1'b0; dif.abort = 1'b0;
      test_reset();
      test_small();
      test_large();
      test_pause();
      test_abort_run();
      test_abort_pause();
      test_start_abort();
      test_start_busy();
      test_hold_last();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
